// File: rtl/aes_pkg.sv
// Shared AES definitions: mode encodings, per-mode key/round counts, Rcon
// constants and the key-schedule FSM states.
package aes_pkg;

    localparam logic [1:0] MODE_128     = 2'b00;
    localparam logic [1:0] MODE_192     = 2'b01;
    localparam logic [1:0] MODE_256     = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DONE
    } ks_state_e;

    // Key length in 32-bit words.
    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            MODE_192: nk_of = 4'd6;
            MODE_256: nk_of = 4'd8;
            default:  nk_of = 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_192: nr_of = 4'd12;
            MODE_256: nr_of = 4'd14;
            default:  nr_of = 4'd10;
        endcase
    endfunction

    // Index 0 is the first Rcon used (Rcon[1] in FIPS-197 numbering).
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd0:    rcon_of = 8'h01;
            4'd1:    rcon_of = 8'h02;
            4'd2:    rcon_of = 8'h04;
            4'd3:    rcon_of = 8'h08;
            4'd4:    rcon_of = 8'h10;
            4'd5:    rcon_of = 8'h20;
            4'd6:    rcon_of = 8'h40;
            4'd7:    rcon_of = 8'h80;
            4'd8:    rcon_of = 8'h1b;
            4'd9:    rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte; shared by the key schedule
// and the round datapaths.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 sits in the top byte, so the table reads row by row as in FIPS-197.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] sel;

    assign sel      = {~in_byte, 3'b000};
    assign out_byte = SBOX_TABLE[sel +: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule: one schedule word per clock into a
// word store, with a registered 128-bit round-key read port.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int KEY_W     = 256,
    parameter int MAX_WORDS = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mod,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    output logic             err,
    output logic [3:0]       nr,
    input  logic [3:0]       rk_idx,
    output logic [127:0]     rk_out
);

    ks_state_e        state_q, state_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [3:0]       nr_q, nr_d;
    logic [1:0]       mode_q, mode_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       nk_q, nk_d;
    logic [5:0]       total_q, total_d;
    logic [5:0]       i_q, i_d;
    logic [2:0]       j_q, j_d;
    logic [3:0]       r_q, r_d;
    logic [127:0]     rk_out_q, rk_out_d;

    logic [31:0] key_mem [0:MAX_WORDS-1];

    logic        start_ok, start_bad;
    logic        load_we, exp_we;
    logic [3:0]  nr_sel;
    logic [5:0]  prev_addr, back_addr, rd_base;
    logic [31:0] prev_word, back_word, sub_in, sub_out, temp_word, new_word;

    assign start_ok  = (state_q == ST_IDLE) && start && (mod != MODE_ILLEGAL);
    assign start_bad = (state_q == ST_IDLE) && start && (mod == MODE_ILLEGAL);
    assign nr_sel    = nr_of(mod);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_EXPAND;
            ST_EXPAND: if (i_q == total_q - 6'd1) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done    = (state_q == ST_DONE);
        load_we = (state_q == ST_LOAD);
        exp_we  = (state_q == ST_EXPAND);
    end

    // One new schedule word: w[i] = w[i-Nk] ^ f(w[i-1]).
    assign prev_addr = i_q - 6'd1;
    assign back_addr = i_q - {2'b00, nk_q};
    assign prev_word = key_mem[prev_addr];
    assign back_word = key_mem[back_addr];
    assign sub_in    = (j_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*g +: 8]),
            .out_byte (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        temp_word = prev_word;
        if (j_q == 3'd0)
            temp_word = sub_out ^ {rcon_of(r_q), 24'h000000};
        else if (nk_q == 4'd8 && j_q == 3'd4)
            temp_word = sub_out;
    end

    assign new_word = back_word ^ temp_word;
    assign rd_base  = {rk_idx, 2'b00};

    always_comb begin
        busy_d   = busy_q;
        valid_d  = valid_q;
        err_d    = err_q;
        nr_d     = nr_q;
        mode_d   = mode_q;
        key_d    = key_q;
        nk_d     = nk_q;
        total_d  = total_q;
        i_d      = i_q;
        j_d      = j_q;
        r_d      = r_q;
        rk_out_d = 128'd0;
        if (start_bad) err_d = 1'b1;
        if (start_ok) begin
            mode_d  = mod;
            key_d   = key_in;
            nk_d    = nk_of(mod);
            total_d = {nr_sel + 4'd1, 2'b00};
            valid_d = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
        end
        case (state_q)
            ST_LOAD: begin
                i_d = {2'b00, nk_q};
                j_d = 3'd0;
                r_d = 4'd0;
            end
            ST_EXPAND: begin
                i_d = i_q + 6'd1;
                j_d = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                r_d = (j_q == 3'd0) ? r_q + 4'd1 : r_q;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
                nr_d    = nr_of(mode_q);
            end
            default: ;
        endcase
        if (valid_q && rk_idx <= nr_q)
            rk_out_d = {key_mem[rd_base], key_mem[rd_base + 6'd1],
                        key_mem[rd_base + 6'd2], key_mem[rd_base + 6'd3]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            nr_q     <= 4'd0;
            mode_q   <= MODE_128;
            key_q    <= '0;
            nk_q     <= 4'd4;
            total_q  <= 6'd44;
            i_q      <= 6'd0;
            j_q      <= 3'd0;
            r_q      <= 4'd0;
            rk_out_q <= 128'd0;
        end else begin
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            nr_q     <= nr_d;
            mode_q   <= mode_d;
            key_q    <= key_d;
            nk_q     <= nk_d;
            total_q  <= total_d;
            i_q      <= i_d;
            j_q      <= j_d;
            r_q      <= r_d;
            rk_out_q <= rk_out_d;
        end
    end

    // Schedule storage needs no reset; keys_valid guards every read.
    always_ff @(posedge clk) begin
        if (load_we) begin
            for (int k = 0; k < 8; k++)
                if (k < int'(nk_q)) key_mem[k] <= key_q[KEY_W-1-32*k -: 32];
        end else if (exp_we) begin
            key_mem[i_q] <= new_word;
        end
    end

    assign busy       = busy_q;
    assign keys_valid = valid_q;
    assign err        = err_q;
    assign nr         = nr_q;
    assign rk_out     = rk_out_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: known-answer table, hand-written
// corner sequences and random keys against a FIPS-197 style reference model.
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   mod;
    logic [255:0] key_in;
    logic         busy, done, keys_valid, err;
    logic [3:0]   nr, rk_idx;
    logic [127:0] rk_out;

    always #5 clk = ~clk;

    aes_key_expand_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mod        (mod),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .err        (err),
        .nr         (nr),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [7:0]  sbox_m [0:255];
    logic [31:0] ref_w  [0:59];
    int          ref_nr;

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KFIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    typedef struct {
        logic [1:0]   m;
        logic [255:0] key;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic void model_expand(input logic [1:0] m, input logic [255:0] key);
        int nk, total;
        logic [31:0] temp;
        logic [7:0]  rc;
        nk     = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
        ref_nr = nk + 6;
        total  = 4 * (ref_nr + 1);
        rc     = 8'h01;
        for (int k = 0; k < nk; k++) ref_w[k] = key[255-32*k -: 32];
        for (int i = nk; i < total; i++) begin
            temp = ref_w[i-1];
            if (i % nk == 0) begin
                temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                temp = subw(temp);
            end
            ref_w[i] = ref_w[i-nk] ^ temp;
        end
    endfunction

    function automatic logic [127:0] ref_rk(input int idx);
        if (idx > ref_nr) return 128'd0;
        return {ref_w[4*idx], ref_w[4*idx+1], ref_w[4*idx+2], ref_w[4*idx+3]};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input int idx, output logic [127:0] v);
        rk_idx = 4'(idx);
        tick();
        v = rk_out;
    endtask

    // Full expansion from IDLE: latency, busy/err/done framing and final nr.
    task automatic applyStimulus(input logic [1:0] m, input logic [255:0] key, input string tag);
        int nk, exp_lat, cnt;
        model_expand(m, key);
        nk      = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
        exp_lat = 1 + 4 * (ref_nr + 1) - nk;
        mod     = m;
        key_in  = key;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        key_in = rand256();
        checkOutput($sformatf("%s busy after start", tag), 128'(busy), 128'd1);
        checkOutput($sformatf("%s err after start", tag), 128'(err), 128'd0);
        cnt = 0;
        while (!done && cnt < 200) begin
            tick();
            cnt++;
        end
        checkOutput($sformatf("%s latency", tag), 128'(cnt), 128'(exp_lat));
        tick();
        checkOutput($sformatf("%s done one cycle", tag), 128'(done), 128'd0);
        checkOutput($sformatf("%s keys_valid", tag), 128'(keys_valid), 128'd1);
        checkOutput($sformatf("%s busy end", tag), 128'(busy), 128'd0);
        checkOutput($sformatf("%s nr", tag), 128'(nr), 128'(ref_nr));
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] got;
        logic [1:0]   prev_m;
        logic [255:0] prev_key;
        int           cnt, done_seen;

        vecs[0] = '{2'b00, K128,  1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        vecs[1] = '{2'b00, K128,  10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[2] = '{2'b01, K192,  12, 128'ha4970a331a78dc09c418c271e3a41d5d};
        vecs[3] = '{2'b01, K192,  13, 128'h0};
        vecs[4] = '{2'b10, K256,  14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[5] = '{2'b10, K256,  0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[6] = '{2'b00, KFIPS, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        reset  = 1'b1;
        start  = 1'b0;
        mod    = 2'b00;
        key_in = '0;
        rk_idx = 4'd0;
        build_sbox();
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset busy", 128'(busy), 128'd0);
        checkOutput("reset done", 128'(done), 128'd0);
        checkOutput("reset keys_valid", 128'(keys_valid), 128'd0);
        checkOutput("reset err", 128'(err), 128'd0);
        checkOutput("reset nr", 128'(nr), 128'd0);
        checkOutput("reset rk_out", rk_out, 128'd0);

        prev_m   = 2'b11;
        prev_key = '0;
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].m != prev_m || vecs[v].key != prev_key)
                applyStimulus(vecs[v].m, vecs[v].key, $sformatf("kat%0d", v));
            prev_m   = vecs[v].m;
            prev_key = vecs[v].key;
            read_rk(vecs[v].idx, got);
            checkOutput($sformatf("kat%0d rk%0d", v, vecs[v].idx), got, vecs[v].exp);
        end

        // Illegal mode after a good AES-128 schedule.
        applyStimulus(2'b00, K128, "pre-illegal");
        mod   = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("illegal err", 128'(err), 128'd1);
        checkOutput("illegal busy", 128'(busy), 128'd0);
        repeat (3) tick();
        checkOutput("illegal busy later", 128'(busy), 128'd0);
        checkOutput("illegal keys_valid", 128'(keys_valid), 128'd1);
        checkOutput("illegal err sticky", 128'(err), 128'd1);
        read_rk(10, got);
        checkOutput("illegal rk10", got, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // AES-256 with stray starts mid-run (legal and illegal mode).
        model_expand(2'b10, K256);
        mod    = 2'b10;
        key_in = K256;
        start  = 1'b1;
        tick();
        cnt = 0;
        while (!done && cnt < 200) begin
            start = 1'b0;
            if (cnt == 9) begin
                start  = 1'b1;
                mod    = 2'b00;
                key_in = rand256();
            end else if (cnt == 11) begin
                start = 1'b1;
                mod   = 2'b11;
            end
            tick();
            cnt++;
        end
        start = 1'b0;
        checkOutput("restart latency", 128'(cnt), 128'd53);
        checkOutput("restart err", 128'(err), 128'd0);
        tick();
        checkOutput("restart nr", 128'(nr), 128'd14);
        read_rk(14, got);
        checkOutput("restart rk14", got, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read_rk(7, got);
        checkOutput("restart rk7", got, ref_rk(7));

        // Reset in the middle of an AES-192 expansion.
        mod    = 2'b01;
        key_in = K192;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort busy", 128'(busy), 128'd0);
        checkOutput("abort keys_valid", 128'(keys_valid), 128'd0);
        checkOutput("abort nr", 128'(nr), 128'd0);
        checkOutput("abort rk_out", rk_out, 128'd0);
        done_seen = 0;
        for (int c = 0; c < 60; c++) begin
            if (done) done_seen++;
            tick();
        end
        checkOutput("abort no done", 128'(done_seen), 128'd0);

        // Back-to-back: second start in the cycle right after done.
        applyStimulus(2'b00, KFIPS, "b2b first");
        applyStimulus(2'b10, rand256(), "b2b second");
        for (int idx = 0; idx < 16; idx += 5) begin
            read_rk(idx, got);
            checkOutput($sformatf("b2b rk%0d", idx), got, ref_rk(idx));
        end

        // Random modes and keys, junk in the unused low key bits.
        for (int n = 0; n < 5; n++) begin
            applyStimulus(2'($urandom_range(0, 2)), rand256(), $sformatf("rand%0d", n));
            for (int idx = 0; idx < 16; idx++) begin
                read_rk(idx, got);
                checkOutput($sformatf("rand%0d rk%0d", n, idx), got, ref_rk(idx));
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
